// File: rtl/lcv_mul32_seq.sv
// lcv_mul32_seq: sequential WIDTHxWIDTH -> 2*WIDTH multiplier, four 17x17 signed partial products, valid/ready in and out
module lcv_mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_valid,
    output logic             inp_ready,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             inp_a_signed,
    input  logic             inp_b_signed,
    output logic             outp_valid,
    input  logic             outp_ready,
    output logic [WIDTH-1:0] outp_lo,
    output logic [WIDTH-1:0] outp_hi
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [1:0]           step_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d, pe, pp;
    logic [WIDTH-1:0]     a_q, b_q, lo_q, hi_q;
    logic                 as_q, bs_q, valid_q, accept;
    logic signed [HALF:0] x, y;
    logic signed [2*HALF+1:0] p;

    assign inp_ready  = rst & ((state_q == IDLE) | ((state_q == DONE) & outp_ready));
    assign accept     = inp_valid & inp_ready;
    assign outp_valid = valid_q;
    assign outp_lo    = lo_q;
    assign outp_hi    = hi_q;

    // select the operand halves for this step, multiply signed, align and accumulate
    always_comb begin
        x     = step_q[1] ? $signed({as_q & a_q[WIDTH-1], a_q[WIDTH-1:HALF]}) : $signed({1'b0, a_q[HALF-1:0]});
        y     = step_q[0] ? $signed({bs_q & b_q[WIDTH-1], b_q[WIDTH-1:HALF]}) : $signed({1'b0, b_q[HALF-1:0]});
        p     = x * y;
        pe    = {{(2*WIDTH-2*HALF-2){p[2*HALF+1]}}, p};
        pp    = (step_q == 2'd0) ? pe : ((step_q == 2'd3) ? (pe << WIDTH) : (pe << HALF));
        acc_d = acc_q + pp;
    end

    // control FSM with operand latch, accumulator and registered result
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
            valid_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else if (accept) begin
            a_q     <= inp_a;
            b_q     <= inp_b;
            as_q    <= inp_a_signed;
            bs_q    <= inp_b_signed;
            acc_q   <= '0;
            step_q  <= 2'd0;
            state_q <= RUN;
            valid_q <= 1'b0;
        end else if (state_q == RUN) begin
            acc_q  <= acc_d;
            step_q <= step_q + 2'd1;
            if (step_q == 2'd3) begin
                state_q      <= DONE;
                valid_q      <= 1'b1;
                {hi_q, lo_q} <= acc_d;
            end
        end else if ((state_q == DONE) && outp_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lcv_mul32_seq.sv
// tb_lcv_mul32_seq: directed self-checking bench for lcv_mul32_seq
module tb_lcv_mul32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inp_valid = 1'b0;
    logic        inp_ready;
    logic [31:0] inp_a = '0;
    logic [31:0] inp_b = '0;
    logic        inp_a_signed = 1'b0;
    logic        inp_b_signed = 1'b0;
    logic        outp_valid;
    logic        outp_ready = 1'b0;
    logic [31:0] outp_lo, outp_hi;
    int          checks = 0;
    int          errors = 0;

    lcv_mul32_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready),
        .inp_a(inp_a), .inp_b(inp_b),
        .inp_a_signed(inp_a_signed), .inp_b_signed(inp_b_signed),
        .outp_valid(outp_valid), .outp_ready(outp_ready),
        .outp_lo(outp_lo), .outp_hi(outp_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // called at the negedge right after the accepting posedge
    task automatic wait_result(input string tag, input logic [63:0] exp);
        int cyc = 0;
        check({tag, "_busy"}, {63'd0, inp_ready}, 64'd0);
        while (!outp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd4);
        check({tag, "_res"}, {outp_hi, outp_lo}, exp);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic bs, input logic [63:0] exp, input int hold);
        @(negedge clk);
        inp_a = a; inp_b = b; inp_a_signed = as; inp_b_signed = bs; inp_valid = 1'b1;
        check({tag, "_rdy"}, {63'd0, inp_ready}, 64'd1);
        @(negedge clk);
        inp_valid = 1'b0; inp_a = ~a; inp_b = ~b; inp_a_signed = ~as; inp_b_signed = ~bs;
        wait_result(tag, exp);
        repeat (hold) @(negedge clk);
        check({tag, "_hold"}, {63'd0, outp_valid}, 64'd1);
        outp_ready = 1'b1;
        @(negedge clk);
        outp_ready = 1'b0;
        check({tag, "_pop"}, {63'd0, outp_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] held, exp, ea, eb;
        logic [31:0] ra, rb;
        logic        rsa, rsb;
        bit          stale;
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, outp_valid}, 64'd0);
        check("rst_ready", {63'd0, inp_ready}, 64'd0);
        check("rst_out", {outp_hi, outp_lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {63'd0, inp_ready}, 64'd1);

        do_op("uu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 0);
        do_op("ss_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_00000001, 1);
        do_op("ss_min", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000, 0);
        do_op("su_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF_00000001, 2);
        do_op("us_7", 32'h00000007, 32'hFFFFFFFD, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFEB, 0);
        do_op("uu_2p16", 32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h00000001_00000000, 0);
        do_op("su_m5", 32'hFFFFFFFF, 32'h00000005, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFB, 0);
        do_op("zero", 32'h00000000, 32'hDEADBEEF, 1'b1, 1'b1, 64'h0, 0);

        // backpressure then handshake-and-accept on the same edge
        @(negedge clk);
        inp_a = 32'hFFFFFFFF; inp_b = 32'h00000002; inp_a_signed = 1'b0; inp_b_signed = 1'b0; inp_valid = 1'b1;
        @(negedge clk);
        inp_a = 32'd3; inp_b = 32'd5;
        wait_result("bp", 64'h00000001_FFFFFFFE);
        held = {outp_hi, outp_lo};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_stable", {outp_hi, outp_lo}, held);
            check("bp_valid", {63'd0, outp_valid}, 64'd1);
            check("bp_nordy", {63'd0, inp_ready}, 64'd0);
        end
        outp_ready = 1'b1;
        #1;
        check("b2b_rdy", {63'd0, inp_ready}, 64'd1);
        @(negedge clk);
        outp_ready = 1'b0; inp_valid = 1'b0;
        check("b2b_drop", {63'd0, outp_valid}, 64'd0);
        wait_result("b2b", 64'd15);
        outp_ready = 1'b1;
        @(negedge clk);
        outp_ready = 1'b0;

        // reset in the middle of an operation
        @(negedge clk);
        inp_a = 32'h12345678; inp_b = 32'h9ABCDEF0; inp_a_signed = 1'b0; inp_b_signed = 1'b0; inp_valid = 1'b1;
        @(negedge clk);
        inp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_rdy0", {63'd0, inp_ready}, 64'd0);
        rst = 1'b1;
        #1;
        check("mrst_rdy1", {63'd0, inp_ready}, 64'd1);
        check("mrst_valid", {63'd0, outp_valid}, 64'd0);
        check("mrst_out", {outp_hi, outp_lo}, 64'd0);
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (outp_valid) stale = 1'b1;
        end
        check("mrst_stale", {63'd0, stale}, 64'd0);

        // randomized operands against a full-width reference product
        for (int n = 0; n < 300; n++) begin
            ra = $urandom; rb = $urandom;
            rsa = 1'($urandom_range(0, 1)); rsb = 1'($urandom_range(0, 1));
            ea = rsa ? {{32{ra[31]}}, ra} : {32'd0, ra};
            eb = rsb ? {{32{rb[31]}}, rb} : {32'd0, rb};
            exp = ea * eb;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op("rnd", ra, rb, rsa, rsb, exp, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
